// File: rtl/sysahb_pkg.sv
// sysahb_pkg: shared AHB-Lite encodings, master indices and control bundle for the system-bus arbiter.
package sysahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_BUSY = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ = 2'b11;
  localparam logic [1:0] HRESP_OKAY = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;
  typedef enum logic [1:0] {DP_NONE, DP_M0, DP_M1} dphase_t;
  typedef struct packed {
    logic [1:0] htrans;
    logic       hwrite;
    logic [2:0] hsize;
    logic [2:0] hburst;
    logic [3:0] hprot;
  } ahb_ctrl_t;
endpackage

// File: rtl/ahb_addr_hold.sv
// ahb_addr_hold: per-master address-phase capture register; capture wins over clear.
module ahb_addr_hold
  import sysahb_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          capture,
  input  logic          clear,
  input  logic [AW-1:0] live_addr,
  input  ahb_ctrl_t     live_ctrl,
  output logic          valid,
  output logic [AW-1:0] addr,
  output ahb_ctrl_t     ctrl
);
  always_ff @(posedge clk)
    if (rst) begin
      valid <= 1'b0;
      addr <= '0;
      ctrl <= '0;
    end else if (capture) begin
      valid <= 1'b1;
      addr <= live_addr;
      ctrl <= live_ctrl;
    end else if (clear) valid <= 1'b0;
endmodule

// File: rtl/sysahb_arbiter2.sv
// sysahb_arbiter2: two-master AHB-Lite arbiter sharing one slave port, stalling the loser via a hold register.
module sysahb_arbiter2 #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter bit RR = 1'b1
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic [AW-1:0] m0_haddr,
  input  logic [1:0]    m0_htrans,
  input  logic          m0_hwrite,
  input  logic [2:0]    m0_hsize,
  input  logic [2:0]    m0_hburst,
  input  logic [3:0]    m0_hprot,
  input  logic [DW-1:0] m0_hwdata,
  output logic [DW-1:0] m0_hrdata,
  output logic          m0_hready,
  output logic [1:0]    m0_hresp,
  input  logic [AW-1:0] m1_haddr,
  input  logic [1:0]    m1_htrans,
  input  logic          m1_hwrite,
  input  logic [2:0]    m1_hsize,
  input  logic [2:0]    m1_hburst,
  input  logic [3:0]    m1_hprot,
  input  logic [DW-1:0] m1_hwdata,
  output logic [DW-1:0] m1_hrdata,
  output logic          m1_hready,
  output logic [1:0]    m1_hresp,
  output logic [AW-1:0] s_haddr,
  output logic [1:0]    s_htrans,
  output logic          s_hwrite,
  output logic [2:0]    s_hsize,
  output logic [2:0]    s_hburst,
  output logic [3:0]    s_hprot,
  output logic [DW-1:0] s_hwdata,
  input  logic [DW-1:0] s_hrdata,
  input  logic          s_hready,
  input  logic [1:0]    s_hresp
);
  import sysahb_pkg::*;
  dphase_t dphase, dphase_nx;
  logic last_grant, win, grant, req0, req1, cand0, cand1, own0, own1, p0_v, p1_v;
  logic [AW-1:0] p0_addr, p1_addr, win_addr, last_addr;
  ahb_ctrl_t c0, c1, p0_ctrl, p1_ctrl, win_ctrl, idle_ctrl, last_ctrl, s_ctrl;
  assign c0 = {m0_htrans, m0_hwrite, m0_hsize, m0_hburst, m0_hprot};
  assign c1 = {m1_htrans, m1_hwrite, m1_hsize, m1_hburst, m1_hprot};
  assign own0 = dphase == DP_M0;
  assign own1 = dphase == DP_M1;
  assign m0_hready = own0 ? s_hready : ~p0_v;
  assign m1_hready = own1 ? s_hready : ~p1_v;
  assign req0 = m0_hready & m0_htrans[1];
  assign req1 = m1_hready & m1_htrans[1];
  assign cand0 = p0_v | req0;
  assign cand1 = p1_v | req1;
  assign grant = s_hready & (cand0 | cand1);
  assign win = (cand0 & cand1) ? (RR ? ~last_grant : M0) : cand1;
  ahb_addr_hold #(.AW(AW)) u_hold0 (
    .clk(sys_clk), .rst(sys_rst),
    .capture(req0 & ~(grant & (win == M0))), .clear(grant & (win == M0) & p0_v),
    .live_addr(m0_haddr), .live_ctrl(c0),
    .valid(p0_v), .addr(p0_addr), .ctrl(p0_ctrl)
  );
  ahb_addr_hold #(.AW(AW)) u_hold1 (
    .clk(sys_clk), .rst(sys_rst),
    .capture(req1 & ~(grant & (win == M1))), .clear(grant & (win == M1) & p1_v),
    .live_addr(m1_haddr), .live_ctrl(c1),
    .valid(p1_v), .addr(p1_addr), .ctrl(p1_ctrl)
  );
  // Remembered fields carry htrans=IDLE so the idle bus replays everything but the transfer type.
  always_comb begin
    win_addr = win ? (p1_v ? p1_addr : m1_haddr) : (p0_v ? p0_addr : m0_haddr);
    win_ctrl = win ? (p1_v ? p1_ctrl : c1) : (p0_v ? p0_ctrl : c0);
    idle_ctrl = win_ctrl;
    idle_ctrl.htrans = HTRANS_IDLE;
    s_ctrl = grant ? win_ctrl : last_ctrl;
    dphase_nx = !s_hready ? dphase : !grant ? DP_NONE : win ? DP_M1 : DP_M0;
  end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      dphase <= DP_NONE;
      last_grant <= M1;
      last_addr <= '0;
      last_ctrl <= '0;
    end else begin
      dphase <= dphase_nx;
      if (grant) begin
        last_grant <= win;
        last_addr <= win_addr;
        last_ctrl <= idle_ctrl;
      end
    end
  assign s_haddr = grant ? win_addr : last_addr;
  assign s_htrans = s_ctrl.htrans;
  assign s_hwrite = s_ctrl.hwrite;
  assign s_hsize = s_ctrl.hsize;
  assign s_hburst = s_ctrl.hburst;
  assign s_hprot = s_ctrl.hprot;
  assign s_hwdata = own1 ? m1_hwdata : m0_hwdata;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;
  assign m0_hresp = own0 ? s_hresp : HRESP_OKAY;
  assign m1_hresp = own1 ? s_hresp : HRESP_OKAY;
endmodule

// File: tb/tb_sysahb_arbiter2.sv
// tb_sysahb_arbiter2: directed vector table plus hand sequences for round-robin, fixed priority and reset.
module tb_sysahb_arbiter2;
  import sysahb_pkg::*;
  localparam logic [1:0] I = HTRANS_IDLE;
  localparam logic [1:0] N = HTRANS_NONSEQ;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] m0_haddr, m1_haddr, m0_hwdata, m1_hwdata, s_hrdata;
  logic [1:0] m0_htrans, m1_htrans, s_hresp;
  logic m0_hwrite, m1_hwrite, s_hready;
  logic [2:0] hsize = 3'b010, hburst = 3'b000;
  logic [3:0] hprot = 4'b0011;
  logic [31:0] m0_hrdata, m1_hrdata, s_haddr, s_hwdata, f_m0_hrdata, f_m1_hrdata, f_haddr, f_hwdata;
  logic m0_hready, m1_hready, s_hwrite, f_m0_hready, f_m1_hready, f_hwrite;
  logic [1:0] m0_hresp, m1_hresp, s_htrans, f_m0_hresp, f_m1_hresp, f_htrans;
  logic [2:0] s_hsize, s_hburst, f_hsize, f_hburst;
  logic [3:0] s_hprot, f_hprot;
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  sysahb_arbiter2 #(.AW(32), .DW(32), .RR(1'b1)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(hsize),
    .m0_hburst(hburst), .m0_hprot(hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(m0_hrdata),
    .m0_hready(m0_hready), .m0_hresp(m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(hsize),
    .m1_hburst(hburst), .m1_hprot(hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(m1_hrdata),
    .m1_hready(m1_hready), .m1_hresp(m1_hresp),
    .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
    .s_hburst(s_hburst), .s_hprot(s_hprot), .s_hwdata(s_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp)
  );

  sysahb_arbiter2 #(.AW(32), .DW(32), .RR(1'b0)) dut_fp (
    .sys_clk(clk), .sys_rst(rst),
    .m0_haddr(m0_haddr), .m0_htrans(m0_htrans), .m0_hwrite(m0_hwrite), .m0_hsize(hsize),
    .m0_hburst(hburst), .m0_hprot(hprot), .m0_hwdata(m0_hwdata), .m0_hrdata(f_m0_hrdata),
    .m0_hready(f_m0_hready), .m0_hresp(f_m0_hresp),
    .m1_haddr(m1_haddr), .m1_htrans(m1_htrans), .m1_hwrite(m1_hwrite), .m1_hsize(hsize),
    .m1_hburst(hburst), .m1_hprot(hprot), .m1_hwdata(m1_hwdata), .m1_hrdata(f_m1_hrdata),
    .m1_hready(f_m1_hready), .m1_hresp(f_m1_hresp),
    .s_haddr(f_haddr), .s_htrans(f_htrans), .s_hwrite(f_hwrite), .s_hsize(f_hsize),
    .s_hburst(f_hburst), .s_hprot(f_hprot), .s_hwdata(f_hwdata), .s_hrdata(s_hrdata),
    .s_hready(s_hready), .s_hresp(s_hresp)
  );

  typedef struct {
    logic [1:0] t0; logic [31:0] a0; logic w0; logic [31:0] d0;
    logic [1:0] t1; logic [31:0] a1; logic [31:0] d1;
    logic sr; logic [1:0] rs; logic [31:0] rd;
    logic [1:0] st; logic [31:0] sa; logic [31:0] sw;
    logic r0, r1; logic [1:0] e0, e1;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t v(logic [1:0] t0, logic [31:0] a0, logic w0, logic [31:0] d0,
                             logic [1:0] t1, logic [31:0] a1, logic [31:0] d1,
                             logic sr, logic [1:0] rs, logic [31:0] rd,
                             logic [1:0] st, logic [31:0] sa, logic [31:0] sw,
                             logic r0, logic r1, logic [1:0] e0, logic [1:0] e1);
    vec_t x;
    x.t0 = t0; x.a0 = a0; x.w0 = w0; x.d0 = d0; x.t1 = t1; x.a1 = a1; x.d1 = d1;
    x.sr = sr; x.rs = rs; x.rd = rd; x.st = st; x.sa = sa; x.sw = sw;
    x.r0 = r0; x.r1 = r1; x.e0 = e0; x.e1 = e1;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] t0, input logic [31:0] a0, input logic [1:0] t1,
                       input logic [31:0] a1, input logic sr);
    m0_htrans = t0; m0_haddr = a0; m0_hwrite = 1'b0; m0_hwdata = '0;
    m1_htrans = t1; m1_haddr = a1; m1_hwrite = 1'b0; m1_hwdata = '0;
    s_hready = sr; s_hresp = HRESP_OKAY; s_hrdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = v(N, 32'h2000_0000, 1, 0, I, 0, 0, 1, 0, 0, N, 32'h2000_0000, 0, 1, 1, 0, 0);
    tbl[1]  = v(I, 0, 0, 32'hDEAD_BEEF, I, 0, 0, 1, 0, 0, I, 32'h2000_0000, 32'hDEAD_BEEF, 1, 1, 0, 0);
    tbl[2]  = v(I, 0, 0, 0, N, 32'h30, 0, 1, 0, 0, N, 32'h30, 0, 1, 1, 0, 0);
    tbl[3]  = v(N, 32'h10, 0, 32'h2222_0002, N, 32'h20, 32'h1111_0001, 1, 0, 32'h1234_5678,
                N, 32'h10, 32'h1111_0001, 1, 1, 0, 0);
    tbl[4]  = v(I, 0, 0, 32'h3333_0003, N, 32'h20, 32'h4444_0004, 1, 0, 32'hAAAA_0010,
                N, 32'h20, 32'h3333_0003, 1, 0, 0, 0);
    tbl[5]  = v(I, 0, 0, 0, I, 0, 0, 1, 0, 32'hBBBB_0020, I, 32'h20, 0, 1, 1, 0, 0);
    tbl[6]  = v(N, 32'h40, 1, 0, N, 32'h50, 0, 1, 0, 0, N, 32'h40, 0, 1, 1, 0, 0);
    tbl[7]  = v(I, 0, 0, 32'hCAFE_0040, N, 32'h50, 32'h7777_0007, 0, 0, 0,
                I, 32'h40, 32'hCAFE_0040, 0, 0, 0, 0);
    tbl[8]  = tbl[7];
    tbl[9]  = tbl[7];
    tbl[10] = v(I, 0, 0, 32'hCAFE_0040, N, 32'h50, 32'h7777_0007, 1, 0, 0,
                N, 32'h50, 32'hCAFE_0040, 1, 0, 0, 0);
    tbl[11] = v(N, 32'h60, 0, 32'h6666_0006, I, 0, 32'h5555_0005, 0, HRESP_ERROR, 0,
                I, 32'h50, 32'h5555_0005, 1, 0, 0, HRESP_ERROR);
    tbl[12] = v(N, 32'h60, 0, 32'h6666_0006, I, 0, 32'h5555_0005, 1, HRESP_ERROR, 0,
                N, 32'h60, 32'h5555_0005, 0, 1, 0, HRESP_ERROR);
    tbl[13] = v(I, 0, 0, 0, I, 0, 0, 1, 0, 32'h0000_600D, I, 32'h60, 0, 1, 1, 0, 0);
    tbl[14] = v(I, 0, 0, 0, N, 32'h70, 0, 1, 0, 0, N, 32'h70, 0, 1, 1, 0, 0);
    tbl[15] = v(I, 0, 0, 0, I, 0, 0, 1, 0, 0, I, 32'h70, 0, 1, 1, 0, 0);

    drive(I, 0, I, 0, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.s_htrans", s_htrans, I);
    chk("rst.s_haddr", s_haddr, 0);
    chk("rst.m0_hready", m0_hready, 1);
    chk("rst.m1_hready", m1_hready, 1);
    chk("rst.m0_hresp", m0_hresp, HRESP_OKAY);
    chk("rst.m1_hresp", m1_hresp, HRESP_OKAY);
    next_cycle();

    for (int i = 0; i < 16; i++) begin
      m0_htrans = tbl[i].t0; m0_haddr = tbl[i].a0; m0_hwrite = tbl[i].w0; m0_hwdata = tbl[i].d0;
      m1_htrans = tbl[i].t1; m1_haddr = tbl[i].a1; m1_hwrite = 1'b0; m1_hwdata = tbl[i].d1;
      s_hready = tbl[i].sr; s_hresp = tbl[i].rs; s_hrdata = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("v%0d.s_htrans", i), s_htrans, tbl[i].st);
      chk($sformatf("v%0d.s_haddr", i), s_haddr, tbl[i].sa);
      chk($sformatf("v%0d.s_hwdata", i), s_hwdata, tbl[i].sw);
      chk($sformatf("v%0d.m0_hready", i), m0_hready, tbl[i].r0);
      chk($sformatf("v%0d.m1_hready", i), m1_hready, tbl[i].r1);
      chk($sformatf("v%0d.m0_hresp", i), m0_hresp, tbl[i].e0);
      chk($sformatf("v%0d.m1_hresp", i), m1_hresp, tbl[i].e1);
      chk($sformatf("v%0d.m0_hrdata", i), m0_hrdata, tbl[i].rd);
      chk($sformatf("v%0d.m1_hrdata", i), m1_hrdata, tbl[i].rd);
      next_cycle();
    end

    // Both masters request every cycle: RR alternates from M0, fixed priority keeps M0.
    for (int k = 0; k < 6; k++) begin
      drive(N, 32'h100, N, 32'h200, 1'b1);
      @(negedge clk);
      chk($sformatf("rr%0d.s_htrans", k), s_htrans, N);
      chk($sformatf("rr%0d.s_haddr", k), s_haddr, (k % 2 == 0) ? 32'h100 : 32'h200);
      chk($sformatf("fp%0d.s_haddr", k), f_haddr, 32'h100);
      chk($sformatf("fp%0d.m1_hready", k), f_m1_hready, (k == 0) ? 1'b1 : 1'b0);
      next_cycle();
    end
    drive(I, 0, I, 0, 1'b1);
    @(negedge clk);
    chk("drain.rr_haddr", s_haddr, 32'h100);
    chk("drain.fp_haddr", f_haddr, 32'h200);
    chk("drain.fp_htrans", f_htrans, N);
    next_cycle();
    @(negedge clk);
    chk("drain2.rr_htrans", s_htrans, I);
    chk("drain2.fp_htrans", f_htrans, I);
    next_cycle();

    // Reset with M0 in its data phase and M1 held pending.
    drive(N, 32'h400, I, 0, 1'b1);
    @(negedge clk);
    chk("pre.s_haddr", s_haddr, 32'h400);
    next_cycle();
    drive(I, 0, N, 32'h500, 1'b0);
    @(negedge clk);
    chk("pre.m1_hready_live", m1_hready, 1);
    chk("pre.s_htrans_wait", s_htrans, I);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("pre.m1_hready_pend", m1_hready, 0);
    chk("pre.m0_hready_wait", m0_hready, 0);
    next_cycle();
    rst = 1'b0;
    drive(I, 0, I, 0, 1'b1);
    @(negedge clk);
    chk("post.s_htrans", s_htrans, I);
    chk("post.s_haddr", s_haddr, 0);
    chk("post.m0_hready", m0_hready, 1);
    chk("post.m1_hready", m1_hready, 1);
    next_cycle();
    drive(N, 32'h800, N, 32'h900, 1'b1);
    @(negedge clk);
    chk("post.rr_first", s_haddr, 32'h800);
    chk("post.fp_first", f_haddr, 32'h800);
    next_cycle();
    drive(I, 0, I, 0, 1'b1);
    @(negedge clk);
    chk("post.rr_second", s_haddr, 32'h900);
    chk("post.m1_hready_held", m1_hready, 0);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
